// File: rtl/clkdiv_seq_ctrl_if.sv
// Sequencer <-> CLKDIV / slow-domain signal bundle.
// master: the sequencer; slave: whatever supplies lock/requests and consumes the controls.
interface clkdiv_seq_ctrl_if;
    logic       pll_lock;
    logic       calib_req;
    logic       div_resetn;
    logic       div_calib;
    logic       calib_ack;
    logic       ready;
    logic       slow_rst;
    logic [7:0] relock_count;

    modport master (
        input  pll_lock, calib_req,
        output div_resetn, div_calib, calib_ack, ready, slow_rst, relock_count
    );

    modport slave (
        output pll_lock, calib_req,
        input  div_resetn, div_calib, calib_ack, ready, slow_rst, relock_count
    );
endinterface

// File: rtl/clkdiv_seq_ctrl.sv
// Bring-up / calibration sequencer for the div-by-8 CLKDIV clock.
// WAIT_LOCK -> HOLD_RST -> SETTLE -> RUN, falling back to WAIT_LOCK on lock loss.
// All outputs are registered and change in the same cycle as the state they decode.
module clkdiv_seq_ctrl #(
    parameter int unsigned LOCK_CYCLES   = 16,
    parameter int unsigned RST_CYCLES    = 8,
    parameter int unsigned SETTLE_CYCLES = 32,
    parameter int unsigned CALIB_GAP     = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    clkdiv_seq_ctrl_if.master    bus
);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD_RST,
        SETTLE,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(CALIB_GAP);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] gap;
    logic             resetn_reg;
    logic             calib_reg;
    logic             ack_reg;
    logic             ready_reg;
    logic             slow_rst_reg;
    logic [7:0]       relock_reg;
    logic             calib_ok;

    // Accept a calib request for the coming cycle when that cycle is RUN
    // (including the SETTLE->RUN edge) and the spacing window has expired.
    // A low pll_lock turns the coming cycle into WAIT_LOCK, so it vetoes the pulse.
    always_comb begin
        calib_ok = bus.calib_req && bus.pll_lock && (gap == '0) &&
                   ((state == RUN) || ((state == SETTLE) && (cnt == SETTLE_LAST)));
    end

    // Sequencer FSM with its registered Moore outputs, calib pulse and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            gap          <= '0;
            resetn_reg   <= 1'b0;
            calib_reg    <= 1'b0;
            ack_reg      <= 1'b0;
            ready_reg    <= 1'b0;
            slow_rst_reg <= 1'b1;
            relock_reg   <= '0;
        end else begin
            calib_reg <= calib_ok;
            ack_reg   <= calib_ok;

            if (calib_ok)
                gap <= GAP_LOAD;
            else if (gap != '0)
                gap <= gap - CNT_W'(1);

            if (state == WAIT_LOCK) begin
                resetn_reg   <= 1'b0;
                ready_reg    <= 1'b0;
                slow_rst_reg <= 1'b1;
                if (!bus.pll_lock) begin
                    cnt <= '0;
                end else if (cnt == LOCK_LAST) begin
                    state <= HOLD_RST;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (!bus.pll_lock) begin
                // Lock lost after sequencing began: restart from scratch and count it.
                state        <= WAIT_LOCK;
                cnt          <= '0;
                gap          <= '0;
                resetn_reg   <= 1'b0;
                ready_reg    <= 1'b0;
                slow_rst_reg <= 1'b1;
                if (relock_reg != 8'hFF)
                    relock_reg <= relock_reg + 8'd1;
            end else begin
                case (state)
                    HOLD_RST: begin
                        if (cnt == RST_LAST) begin
                            state      <= SETTLE;
                            cnt        <= '0;
                            resetn_reg <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    SETTLE: begin
                        if (cnt == SETTLE_LAST) begin
                            state        <= RUN;
                            cnt          <= '0;
                            ready_reg    <= 1'b1;
                            slow_rst_reg <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        resetn_reg   <= 1'b1;
                        ready_reg    <= 1'b1;
                        slow_rst_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.div_resetn   = resetn_reg;
    assign bus.div_calib    = calib_reg;
    assign bus.calib_ack    = ack_reg;
    assign bus.ready        = ready_reg;
    assign bus.slow_rst     = slow_rst_reg;
    assign bus.relock_count = relock_reg;

endmodule

// File: tb/tb_clkdiv_seq_ctrl.sv
// Bench for clkdiv_seq_ctrl: a timeline-based reference model pushes the
// expected outputs of every cycle into a queue; a negedge monitor pops and
// compares. Directed checks pin the absolute cycle numbers of key events.
module tb_clkdiv_seq_ctrl;

    localparam int LOCK   = 16;
    localparam int RSTC   = 8;
    localparam int SETTLE = 32;
    localparam int GAP    = 16;

    typedef struct packed {
        logic       div_resetn;
        logic       div_calib;
        logic       calib_ack;
        logic       ready;
        logic       slow_rst;
        logic [7:0] relock;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    clkdiv_seq_ctrl_if bus ();

    clkdiv_seq_ctrl #(
        .LOCK_CYCLES(LOCK), .RST_CYCLES(RSTC), .SETTLE_CYCLES(SETTLE),
        .CALIB_GAP(GAP), .CNT_W(16)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    // Reference model: tracks time since sequencing began rather than states.
    bit     m_seq = 0;
    int     m_lock_run = 0;
    int     m_elapsed = 0;
    int     m_relock = 0;
    longint m_cyc = 0;
    longint m_last_pulse = -1000000;

    always @(posedge clk) begin
        obs_t e;
        bit   pulse;
        pulse = 0;
        m_cyc++;
        if (rst) begin
            m_seq = 0; m_lock_run = 0; m_elapsed = 0; m_relock = 0;
            m_last_pulse = -1000000;
        end else if (!m_seq) begin
            if (bus.pll_lock) begin
                m_lock_run++;
                if (m_lock_run == LOCK) begin
                    m_seq = 1; m_elapsed = 0; m_lock_run = 0;
                end
            end else begin
                m_lock_run = 0;
            end
        end else if (!bus.pll_lock) begin
            m_seq = 0; m_lock_run = 0;
            if (m_relock < 255) m_relock++;
            m_last_pulse = -1000000;
        end else begin
            m_elapsed++;
            if (m_elapsed >= RSTC + SETTLE && bus.calib_req &&
                m_cyc - m_last_pulse >= GAP + 1) begin
                pulse = 1;
                m_last_pulse = m_cyc;
            end
        end
        e.div_resetn = m_seq && (m_elapsed >= RSTC);
        e.ready      = m_seq && (m_elapsed >= RSTC + SETTLE);
        e.slow_rst   = !e.ready;
        e.div_calib  = pulse;
        e.calib_ack  = pulse;
        e.relock     = 8'(m_relock);
        exp_q.push_back(e);
    end

    // Monitor: compare each cycle's outputs with the model's prediction.
    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.div_resetn, bus.div_calib, bus.calib_ack, bus.ready,
                 bus.slow_rst, bus.relock_count};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL scoreboard @%0t: got %b expected %b", $time, a, e);
            end
        end
    end

    int cyc;
    int pulse_q[$];

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.div_calib === 1'b1) pulse_q.push_back(cyc);
        end
    endtask

    task automatic go_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        step(n);
        rst = 1'b0;
        cyc = 0;
        pulse_q.delete();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d required %0d", name, cyc, got, want);
        end
    endtask

    initial begin
        int r;
        rst = 1'b1;
        bus.pll_lock  = 1'b1;
        bus.calib_req = 1'b0;
        cyc = 0;

        // Clean bring-up with lock high throughout.
        do_reset(4);
        chk("reset_resetn", bus.div_resetn, 0);
        chk("reset_slow_rst", bus.slow_rst, 1);
        chk("reset_ready", bus.ready, 0);
        chk("reset_relock", bus.relock_count, 0);
        go_to(23); chk("resetn_c23", bus.div_resetn, 0);
        go_to(24); chk("resetn_c24", bus.div_resetn, 1);
        go_to(55); chk("ready_c55", bus.ready, 0);
        go_to(56); chk("ready_c56", bus.ready, 1);
        chk("slow_rst_c56", bus.slow_rst, 0);
        go_to(60); chk("no_calib", pulse_q.size(), 0);

        // Lock glitch before sequencing: restart count, no relock.
        do_reset(1);
        go_to(10); bus.pll_lock = 1'b0;
        go_to(11); bus.pll_lock = 1'b1;
        go_to(34); chk("glitch_resetn_c34", bus.div_resetn, 0);
        go_to(35); chk("glitch_resetn_c35", bus.div_resetn, 1);
        chk("glitch_relock", bus.relock_count, 0);
        go_to(66); chk("glitch_ready_c66", bus.ready, 0);
        go_to(67); chk("glitch_ready_c67", bus.ready, 1);

        // Lock loss in RUN for 3 cycles.
        go_to(70); bus.pll_lock = 1'b0;
        go_to(71);
        chk("loss_ready", bus.ready, 0);
        chk("loss_slow_rst", bus.slow_rst, 1);
        chk("loss_resetn", bus.div_resetn, 0);
        chk("loss_relock", bus.relock_count, 1);
        go_to(73); bus.pll_lock = 1'b1;
        go_to(128); chk("relock_ready_c128", bus.ready, 0);
        go_to(129); chk("relock_ready_c129", bus.ready, 1);

        // Held calib request: pulses spaced CALIB_GAP+1 apart.
        go_to(135); r = cyc; pulse_q.delete(); bus.calib_req = 1'b1;
        go_to(r + 40); bus.calib_req = 1'b0;
        go_to(r + 50);
        chk("held_pulse_count", pulse_q.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("held_pulse_at", (i < pulse_q.size()) ? pulse_q[i] : -1, r + 1 + i * (GAP + 1));

        // Request raised in SETTLE waits for the first RUN cycle.
        do_reset(2);
        go_to(30); bus.calib_req = 1'b1;
        go_to(55); chk("settle_no_ack", pulse_q.size(), 0);
        go_to(56);
        chk("first_run_ack", bus.calib_ack, 1);
        chk("first_run_calib", bus.div_calib, 1);
        bus.calib_req = 1'b0;
        go_to(57); chk("ack_one_cycle", bus.calib_ack, 0);

        // Lock loss coincident with an accept: loss wins.
        go_to(80);
        chk("single_pulse", pulse_q.size(), 1);
        bus.calib_req = 1'b1; bus.pll_lock = 1'b0;
        go_to(81);
        chk("loss_vs_accept_calib", bus.div_calib, 0);
        chk("loss_vs_accept_relock", bus.relock_count, 1);
        bus.calib_req = 1'b0; bus.pll_lock = 1'b1;

        // 300 lock losses saturate the counter.
        repeat (300) begin
            bus.pll_lock = 1'b1; step(17);
            bus.pll_lock = 1'b0; step(1);
        end
        chk("relock_sat", bus.relock_count, 255);

        // rst mid-SETTLE restores every reset value.
        bus.pll_lock = 1'b1;
        step(LOCK + RSTC + 5);
        chk("in_settle_resetn", bus.div_resetn, 1);
        rst = 1'b1; step(1); rst = 1'b0;
        chk("rst_resetn", bus.div_resetn, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_slow_rst", bus.slow_rst, 1);
        chk("rst_calib", bus.div_calib, 0);
        chk("rst_ack", bus.calib_ack, 0);
        chk("rst_relock", bus.relock_count, 0);

        // Random traffic, checked by the scoreboard only.
        repeat (4000) begin
            rst           = ($urandom_range(0, 1499) == 0);
            bus.pll_lock  = ($urandom_range(0, 149) != 0);
            bus.calib_req = ($urandom_range(0, 2) != 0);
            step(1);
        end
        rst = 1'b0;
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clkdiv_seq_ctrl.md
Name: clkdiv_seq_ctrl

Overview:
- Bring-up and calibration sequencer for the CLKDIV-based divided clock (div-by-8 from the PLL high-speed clock).
- Waits for a stable PLL lock, then holds the divider in reset and releases it.
- After release, waits for the divided clock to settle, then releases the slow-domain reset and reports ready.
- Afterwards it arbitrates CALIB (clock-slip) requests, enforcing minimum pulse spacing, and re-sequences on any lock loss.
- Runs on a free-running reference clock, not on the divider output.

Parameters:
- LOCK_CYCLES, 16: consecutive pll_lock-high cycles required before sequencing.
- RST_CYCLES, 8: cycles div_resetn is held low in HOLD_RST.
- SETTLE_CYCLES, 32: cycles between divider release and ready.
- CALIB_GAP, 16: idle cycles enforced between consecutive div_calib pulses.
- CNT_W, 16: shared counter width; every *_CYCLES and CALIB_GAP value is >=1 and <2^CNT_W.

Ports:
- clk, in, 1: free-running reference clock.
- rst, in, 1: synchronous, active-high reset.
- pll_lock, in, 1: PLL lock, already synchronised to clk.
- div_resetn, out, 1: drives CLKDIV RESETN (active low).
- div_calib, out, 1: drives CLKDIV CALIB; one-cycle pulse.
- calib_req, in, 1: level request for one CALIB pulse.
- calib_ack, out, 1: one-cycle pulse, same cycle as div_calib.
- ready, out, 1: divided clock valid.
- slow_rst, out, 1: active-high reset for the divided domain; the consumer re-synchronises it.
- relock_count, out, 8: saturating count of lock losses after sequencing began.

Behaviour:
- Outputs are registered, Moore decode of the state plus the calib pulse register.
- Cycle 0 is the first cycle after rst deasserts.
- Reset values: state WAIT_LOCK, div_resetn=0, div_calib=0, calib_ack=0, ready=0, slow_rst=1, relock_count=0, all counters 0.
- WAIT_LOCK: div_resetn=0, ready=0, slow_rst=1.
  - Counter increments each cycle pll_lock=1 and clears on pll_lock=0.
  - On the LOCK_CYCLES-th consecutive high cycle: go to HOLD_RST and clear the counter.
- HOLD_RST: div_resetn=0 for exactly RST_CYCLES cycles, then go to SETTLE.
- SETTLE: div_resetn=1, ready=0, slow_rst=1 for exactly SETTLE_CYCLES cycles, then go to RUN.
- RUN: div_resetn=1, ready=1, slow_rst=0.
- Timing with lock high from cycle 0:
  - HOLD_RST from cycle LOCK_CYCLES.
  - div_resetn rises at LOCK_CYCLES+RST_CYCLES.
  - ready rises at LOCK_CYCLES+RST_CYCLES+SETTLE_CYCLES.
  - Defaults: 16, 24, 56.
- Lock loss: pll_lock=0 in HOLD_RST, SETTLE or RUN means:
  - Next cycle: WAIT_LOCK with all WAIT_LOCK outputs.
  - relock_count increments, saturating at 255.
  - Counters clear and any pending request is not acked.
  - Lock loss while already in WAIT_LOCK does not count.
- Calib arbitration:
  - Accepted only in RUN with the gap counter = 0 and calib_req=1.
  - On acceptance: div_calib=1 and calib_ack=1 for one cycle, and the gap counter loads CALIB_GAP, decrementing to 0.
  - calib_req held high produces pulses at t, t+CALIB_GAP+1, t+2*(CALIB_GAP+1)...
  - Requester drops req the cycle after ack for a single pulse.
- Requests outside RUN stay pending, not acked. Earliest pulse is the first RUN cycle.
- Simultaneous pll_lock=0 and calib accept in RUN: lock loss wins, no pulse, no ack.
- The gap counter clears on leaving RUN.
- rst at any time overrides everything and returns all reset values the next cycle, including relock_count.

Test Plan:
- rst 4 cycles, pll_lock=1 constant -> div_resetn rises cycle 24; ready=1 and slow_rst=0 at cycle 56; div_calib never pulses.
- pll_lock high 10, low 1, then high -> HOLD_RST entered 16 cycles after re-rise; relock_count stays 0.
- In RUN, pll_lock low 3 cycles -> next cycle ready=0, slow_rst=1, div_resetn=0, relock_count=1; ready returns 56 cycles after pll_lock re-rise.
- In RUN, calib_req high 40 cycles from t -> div_calib/calib_ack pulses exactly at t, t+17, t+34 (3 pulses).
- calib_req raised during SETTLE -> no ack until RUN; pulse in the first RUN cycle (cycle 56). Also: pll_lock drops in the same cycle as an accept -> no pulse, relock_count increments.
- 300 lock losses -> relock_count=255; rst pulse mid-SETTLE -> next cycle all outputs at reset values, relock_count=0.
